// File: rtl/icache_2way_param.sv
// Read-only 2-way set-associative instruction cache with true-LRU replacement and flush.
// Define ICACHE_PREFETCH_EN to add a one-entry next-line prefetch buffer.
//
// state      | meaning
// S_IDLE     | serve hits, detect misses, apply flush
// S_FETCH    | line read outstanding, waiting for mem_ready
// S_DONE     | fill written, fetch is re-presented next cycle
// S_PREFETCH | next-line read outstanding, hits still served (prefetch build only)
module icache_2way_param #(
    parameter int ADDR_W   = 30,
    parameter int SET_BITS = 2
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [31:0]       proc_wdata,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic              proc_flush,
    output logic [31:0]       proc_rdata,
    output logic              proc_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ready
);
    localparam int TAG_W  = ADDR_W - 2 - SET_BITS;
    localparam int LINE_W = ADDR_W - 2;
    localparam int SETS   = 1 << SET_BITS;

`ifdef ICACHE_PREFETCH_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE, S_PREFETCH} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;
`endif

    state_t            state_q;
    logic [1:0]        valid_q [SETS];
    logic [SETS-1:0]   lru_q;
    logic [TAG_W-1:0]  tag_q   [SETS][2];
    logic [127:0]      data_q  [SETS][2];
    logic              flush_pend_q;
    logic [LINE_W-1:0] miss_line_q;

    logic [TAG_W-1:0]    req_tag;
    logic [SET_BITS-1:0] req_idx;
    logic [1:0]          req_word;
    logic [LINE_W-1:0]   req_line;
    logic                st_idle, st_fetch, st_done, st_pf;
    logic                hit0, hit1, hit_any, flush_now, serve, miss_req, buf_hit;
    logic [127:0]        hit_line;
    logic                fill_en, fill_way;
    logic [SET_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic [127:0]        fill_data;
    logic                unused_inputs;

    assign unused_inputs = ^{proc_write, proc_wdata};

    assign req_tag  = proc_addr[ADDR_W-1:SET_BITS+2];
    assign req_idx  = proc_addr[SET_BITS+1:2];
    assign req_word = proc_addr[1:0];
    assign req_line = proc_addr[ADDR_W-1:2];

    assign st_idle  = (state_q == S_IDLE);
    assign st_fetch = (state_q == S_FETCH);
    assign st_done  = (state_q == S_DONE);

`ifdef ICACHE_PREFETCH_EN
    logic                buf_valid_q;
    logic [LINE_W-1:0]   buf_line_q;
    logic [127:0]        buf_data_q;
    logic [LINE_W-1:0]   pf_line_q;
    logic [LINE_W-1:0]   next_line;
    logic [SET_BITS-1:0] next_idx;
    logic [TAG_W-1:0]    next_tag;
    logic                next_resident;

    assign st_pf     = (state_q == S_PREFETCH);
    assign buf_hit   = buf_valid_q && (buf_line_q == req_line);
    assign next_line = miss_line_q + LINE_W'(1);
    assign next_idx  = next_line[SET_BITS-1:0];
    assign next_tag  = next_line[LINE_W-1:SET_BITS];
    assign next_resident = (valid_q[next_idx][0] && (tag_q[next_idx][0] == next_tag)) ||
                           (valid_q[next_idx][1] && (tag_q[next_idx][1] == next_tag)) ||
                           (buf_valid_q && (buf_line_q == next_line));
    assign fill_data = st_fetch ? mem_rdata : buf_data_q;
`else
    assign st_pf     = 1'b0;
    assign buf_hit   = 1'b0;
    assign fill_data = mem_rdata;
`endif

    assign hit0     = valid_q[req_idx][0] && (tag_q[req_idx][0] == req_tag);
    assign hit1     = valid_q[req_idx][1] && (tag_q[req_idx][1] == req_tag);
    assign hit_any  = hit0 || hit1;
    assign hit_line = hit1 ? data_q[req_idx][1] : data_q[req_idx][0];

    assign flush_now = st_idle && (proc_flush || flush_pend_q);
    assign serve     = proc_read && hit_any &&
                       ((st_idle && !flush_now) || (st_pf && !proc_flush && !flush_pend_q));
    assign miss_req  = st_idle && proc_read && !hit_any && !flush_now;

    // Victim: an invalid way first (way0 preferred), otherwise the LRU way.
    assign fill_idx = st_fetch ? miss_line_q[SET_BITS-1:0] : req_idx;
    assign fill_tag = st_fetch ? miss_line_q[LINE_W-1:SET_BITS] : req_tag;
    assign fill_way = !valid_q[fill_idx][0] ? 1'b0 :
                      !valid_q[fill_idx][1] ? 1'b1 : lru_q[fill_idx];
    assign fill_en  = !proc_reset && ((st_fetch && mem_ready) || (miss_req && buf_hit));

    assign proc_rdata = serve ? hit_line[{req_word, 5'b0} +: 32] : 32'h0;
    assign proc_stall = st_fetch || st_done || flush_now || (proc_read && !serve);
    assign mem_read   = st_fetch || st_pf || (miss_req && !buf_hit);
    assign mem_write  = 1'b0;
    assign mem_wdata  = '0;

    always_comb begin
        mem_addr = '0;
        if (st_fetch)
            mem_addr = miss_line_q;
        else if (miss_req && !buf_hit)
            mem_addr = req_line;
`ifdef ICACHE_PREFETCH_EN
        else if (st_pf)
            mem_addr = pf_line_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q      <= S_IDLE;
            flush_pend_q <= 1'b0;
            lru_q        <= '0;
            miss_line_q  <= '0;
            for (int s = 0; s < SETS; s++) valid_q[s] <= 2'b00;
`ifdef ICACHE_PREFETCH_EN
            buf_valid_q  <= 1'b0;
            buf_line_q   <= '0;
            pf_line_q    <= '0;
`endif
        end else begin
            if (fill_en) begin
                valid_q[fill_idx][fill_way] <= 1'b1;
                lru_q[fill_idx]             <= ~fill_way;
            end
            if (serve)
                lru_q[req_idx] <= hit0;
            if (!st_idle && proc_flush)
                flush_pend_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (flush_now) begin
                        for (int s = 0; s < SETS; s++) valid_q[s] <= 2'b00;
                        lru_q        <= '0;
                        flush_pend_q <= 1'b0;
`ifdef ICACHE_PREFETCH_EN
                        buf_valid_q  <= 1'b0;
`endif
                    end else if (miss_req) begin
                        miss_line_q <= req_line;
                        state_q     <= buf_hit ? S_DONE : S_FETCH;
`ifdef ICACHE_PREFETCH_EN
                        if (buf_hit) buf_valid_q <= 1'b0;
`endif
                    end
                end
                S_FETCH: if (mem_ready) state_q <= S_DONE;
                S_DONE: begin
                    state_q <= S_IDLE;
`ifdef ICACHE_PREFETCH_EN
                    if (!proc_flush && !flush_pend_q && !next_resident) begin
                        pf_line_q <= next_line;
                        state_q   <= S_PREFETCH;
                    end
`endif
                end
`ifdef ICACHE_PREFETCH_EN
                S_PREFETCH: if (mem_ready) begin
                    buf_valid_q <= 1'b1;
                    buf_line_q  <= pf_line_q;
                    state_q     <= S_IDLE;
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx][fill_way]  <= fill_tag;
            data_q[fill_idx][fill_way] <= fill_data;
        end
`ifdef ICACHE_PREFETCH_EN
        if (st_pf && mem_ready)
            buf_data_q <= mem_rdata;
`endif
    end
endmodule

// File: tb/tb_icache_2way_param.sv
// Self-checking bench for icache_2way_param (default build): directed scenarios plus
// randomized reads checked against a per-set recency-list model.
`timescale 1ns/1ps
module tb_icache_2way_param;
    logic         clk = 1'b0;
    logic         proc_reset = 1'b0, proc_read = 1'b0, proc_write = 1'b0, proc_flush = 1'b0;
    logic [31:0]  proc_wdata = '0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall, mem_read, mem_write, mem_ready = 1'b0;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata = '0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    icache_2way_param dut (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
        .proc_wdata(proc_wdata), .proc_addr(proc_addr), .proc_flush(proc_flush),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Reference model: per set, resident lines ordered most-recent first (at most 2).
    logic [27:0] m_line [4][2];
    int          m_cnt  [4];

    function automatic logic [31:0] mem_word(input logic [27:0] l, input int w);
        return {l, 4'(w)} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] l);
        return {mem_word(l, 3), mem_word(l, 2), mem_word(l, 1), mem_word(l, 0)};
    endfunction

    task automatic model_clear;
        for (int s = 0; s < 4; s++) m_cnt[s] = 0;
    endtask

    task automatic model_access(input logic [27:0] l, output bit hit);
        int s;
        s = int'(l[1:0]);
        hit = 1'b0;
        for (int i = 0; i < m_cnt[s]; i++) if (m_line[s][i] == l) hit = 1'b1;
        if (!(hit && m_line[s][0] == l)) begin
            m_line[s][1] = m_line[s][0];
            m_line[s][0] = l;
            if (!hit && m_cnt[s] < 2) m_cnt[s]++;
        end
    endtask

    task automatic do_reset;
        proc_reset = 1'b1; proc_read = 1'b0; proc_flush = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 proc_reset = 1'b0;
    endtask

    // Holds a fetch until served; mem_ready pulses lat+1 cycles after the miss cycle.
    task automatic do_read(input logic [29:0] a, input int lat, input logic [127:0] line_data,
                           output logic [31:0] d, output int st, output bit ms,
                           output bit mr0, output logic [27:0] ma);
        int k;
        int mk;
        bit got;
        k = 0; mk = 0; got = 1'b0;
        d = '0; st = 0; ms = 1'b0; mr0 = 1'b0; ma = '0;
        proc_addr = a; proc_read = 1'b1; mem_rdata = line_data;
        while (!got && k < 40) begin
            @(negedge clk);
            if (k == 0) mr0 = mem_read;
            if (!proc_stall) begin
                d = proc_rdata; got = 1'b1;
            end else begin
                st++;
                if (mem_read && !ms) begin ms = 1'b1; mk = k; ma = mem_addr; end
            end
            @(posedge clk); #1;
            k++;
            mem_ready = !got && ms && (k == mk + 1 + lat);
        end
        proc_read = 1'b0; mem_ready = 1'b0;
        n_checks++;
        if (!got) $display("FAIL read_timeout addr=%h got=0 required=1", a); else n_pass++;
    endtask

    task automatic test_reset;
        do_reset();
        proc_addr = 30'h10;
        @(negedge clk);
        n_checks++;
        if ({proc_stall, mem_read, mem_write} !== 3'b000)
            $display("FAIL reset_ctrl got=%b required=000", {proc_stall, mem_read, mem_write});
        else n_pass++;
        n_checks++;
        if (proc_rdata !== 32'h0 || mem_addr !== 28'h0 || mem_wdata !== 128'h0)
            $display("FAIL reset_data rdata=%h mem_addr=%h wdata=%h required=0", proc_rdata, mem_addr, mem_wdata);
        else n_pass++;
    endtask

    task automatic test_miss_basic;
        logic [31:0] d; int st; bit ms, mr0; logic [27:0] ma;
        logic [127:0] ld;
        ld = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
        do_read(30'h10, 1, ld, d, st, ms, mr0, ma);
        n_checks++; if (mr0 !== 1'b1) $display("FAIL miss_mem_read got=%b required=1", mr0); else n_pass++;
        n_checks++; if (ma !== 28'h4) $display("FAIL miss_mem_addr got=%h required=4", ma); else n_pass++;
        n_checks++; if (st != 4) $display("FAIL miss_stalls got=%0d required=4", st); else n_pass++;
        n_checks++; if (d !== 32'h1111) $display("FAIL miss_rdata got=%h required=00001111", d); else n_pass++;
        do_read(30'h13, 0, '0, d, st, ms, mr0, ma);
        n_checks++; if (ms || st != 0) $display("FAIL rehit_stall got=%0d required=0", st); else n_pass++;
        n_checks++; if (d !== 32'h4444) $display("FAIL rehit_rdata got=%h required=00004444", d); else n_pass++;
    endtask

    task automatic test_lru;
        logic [31:0] d; int st; bit ms, mr0; logic [27:0] ma;
        logic [29:0] seq [6];
        bit exp_ms [6];
        seq = '{30'h10, 30'h50, 30'h10, 30'h90, 30'h10, 30'h50};
        exp_ms = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_read(seq[i], 0, mem_line(seq[i][29:2]), d, st, ms, mr0, ma);
            n_checks++;
            if (ms !== exp_ms[i]) $display("FAIL lru_step%0d addr=%h miss=%b required=%b", i, seq[i], ms, exp_ms[i]);
            else n_pass++;
            n_checks++;
            if (d !== mem_word(seq[i][29:2], 0)) $display("FAIL lru_data%0d got=%h required=%h", i, d, mem_word(seq[i][29:2], 0));
            else n_pass++;
        end
    endtask

    task automatic test_flush_idle;
        logic [31:0] d; int st; bit ms, mr0; logic [27:0] ma;
        proc_flush = 1'b1;
        @(negedge clk);
        n_checks++; if (proc_stall !== 1'b1) $display("FAIL flush_idle_stall got=%b required=1", proc_stall); else n_pass++;
        @(posedge clk); #1 proc_flush = 1'b0;
        do_read(30'h10, 0, mem_line(28'h4), d, st, ms, mr0, ma);
        n_checks++; if (mr0 !== 1'b1 || ms !== 1'b1) $display("FAIL flush_idle_miss got=%b required=1", mr0); else n_pass++;
        n_checks++; if (ma !== 28'h4) $display("FAIL flush_idle_addr got=%h required=4", ma); else n_pass++;
    endtask

    task automatic test_flush_fetch;
        logic [31:0] d; int st; bit ms, mr0; logic [27:0] ma;
        proc_addr = 30'h20; proc_read = 1'b1; mem_rdata = mem_line(28'h8);
        @(negedge clk);
        n_checks++; if (mem_read !== 1'b1) $display("FAIL ffetch_miss got=%b required=1", mem_read); else n_pass++;
        @(posedge clk); #1 proc_flush = 1'b1;
        @(posedge clk); #1 proc_flush = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        @(posedge clk); #1;
        do_read(30'h20, 0, mem_line(28'h8), d, st, ms, mr0, ma);
        n_checks++; if (ms !== 1'b1 || st != 4) $display("FAIL ffetch_refetch stalls=%0d required=4", st); else n_pass++;
        n_checks++; if (d !== mem_word(28'h8, 0)) $display("FAIL ffetch_data got=%h required=%h", d, mem_word(28'h8, 0)); else n_pass++;
        do_read(30'h10, 0, mem_line(28'h4), d, st, ms, mr0, ma);
        n_checks++; if (ms !== 1'b1) $display("FAIL ffetch_other_line miss=%b required=1", ms); else n_pass++;
    endtask

    task automatic test_reset_fetch;
        logic [31:0] d; int st; bit ms, mr0; logic [27:0] ma;
        proc_addr = 30'h30; proc_read = 1'b1; mem_rdata = mem_line(28'hC);
        @(posedge clk); #1 proc_reset = 1'b1;
        @(posedge clk); #1 proc_reset = 1'b0; proc_read = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_read !== 1'b0) $display("FAIL rfetch_abort got=%b required=0", mem_read); else n_pass++;
        @(posedge clk); #1 mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        do_read(30'h30, 0, mem_line(28'hC), d, st, ms, mr0, ma);
        n_checks++; if (ms !== 1'b1 || st != 3) $display("FAIL rfetch_next_miss stalls=%0d required=3", st); else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] d; int st; bit ms, mr0; logic [27:0] ma;
        logic [27:0] line; int w; int lat; bit exp_hit;
        do_reset();
        model_clear();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                proc_flush = 1'b1;
                @(negedge clk);
                n_checks++; if (proc_stall !== 1'b1) $display("FAIL rand_flush%0d stall=%b required=1", i, proc_stall); else n_pass++;
                @(posedge clk); #1 proc_flush = 1'b0;
                model_clear();
            end else begin
                line = 28'($urandom_range(0, 31));
                w    = int'($urandom_range(0, 3));
                lat  = int'($urandom_range(0, 3));
                model_access(line, exp_hit);
                do_read({line, 2'(w)}, lat, mem_line(line), d, st, ms, mr0, ma);
                n_checks++;
                if (ms !== !exp_hit) $display("FAIL rand_hit%0d line=%h miss=%b required=%b", i, line, ms, !exp_hit);
                else n_pass++;
                n_checks++;
                if (d !== mem_word(line, w)) $display("FAIL rand_data%0d got=%h required=%h", i, d, mem_word(line, w));
                else n_pass++;
                if (!exp_hit) begin
                    n_checks++;
                    if (ma !== line || st != 3 + lat)
                        $display("FAIL rand_fill%0d addr=%h stalls=%0d required addr=%h stalls=%0d", i, ma, st, line, 3 + lat);
                    else n_pass++;
                end else begin
                    n_checks++;
                    if (st != 0) $display("FAIL rand_hitstall%0d got=%0d required=0", i, st); else n_pass++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_miss_basic();
        test_lru();
        test_flush_idle();
        test_flush_fetch();
        test_reset_fetch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end
endmodule
